wb_regfile: RTL and testbench

Register file and write-back scoreboard for the five-stage (IF ID EXE MEM WB) core. Sits directly downstream of the write-back select mux: it consumes the mux's 8-bit result plus the write-back enable, commits it to one of eight architectural registers, and serves two combinational read ports to ID. A per-register in-flight counter tracks writes issued from ID but not yet retired at WB, and drives hazard flags so ID can stall.

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_if.sv | 27 ++
 rtl/wb_regfile_scoreboard.sv | 61 ++++++
 rtl/wb_regfile.sv | 46 ++++
 tb/tb_wb_regfile.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_pkg: shared widths, register/counter types and counter ceiling for wb_regfile
package wb_pkg;
  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);
  localparam int CNT_W  = 2;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;
  localparam sb_cnt_t CNT_MAX = '1;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back, read, issue and flush signals between the core (master) and wb_regfile (slave)
interface wb_regfile_if;
  import wb_pkg::*;
  logic      wb_we;
  reg_addr_t wb_addr;
  reg_data_t wb_data;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  reg_data_t rd_data_a;
  reg_data_t rd_data_b;
  logic      hazard_a;
  logic      hazard_b;
  logic      issue_valid;
  logic      issue_we;
  reg_addr_t issue_dst;
  logic      issue_ready;
  logic      flush;
  logic      sb_err;
  modport master (
    output wb_we, wb_addr, wb_data, rd_addr_a, rd_addr_b, issue_valid, issue_we, issue_dst, flush,
    input  rd_data_a, rd_data_b, hazard_a, hazard_b, issue_ready, sb_err
  );
  modport slave (
    input  wb_we, wb_addr, wb_data, rd_addr_a, rd_addr_b, issue_valid, issue_we, issue_dst, flush,
    output rd_data_a, rd_data_b, hazard_a, hazard_b, issue_ready, sb_err
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// wb_scoreboard: per-register in-flight counters, issue back-pressure, RAW hazard flags and sticky underflow error (REGFILE_BYPASS_EN lets a same-cycle retire clear a hazard)
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic      sysclk,
  input  logic      rst_n,
  input  logic      wb_we_i,
  input  reg_addr_t wb_addr_i,
  input  logic      issue_valid_i,
  input  logic      issue_we_i,
  input  reg_addr_t issue_dst_i,
  input  logic      flush_i,
  input  reg_addr_t rd_addr_a_i,
  input  reg_addr_t rd_addr_b_i,
  output logic      issue_ready_o,
  output logic      hazard_a_o,
  output logic      hazard_b_o,
  output logic      sb_err_o
);
  sb_cnt_t cnt_q [NREGS];
  sb_cnt_t cnt_d [NREGS];
  logic    sb_err_q, sb_err_d;
  logic    retire, accept;
  // Qualify retire/issue, then derive next counters; a matching issue and retire cancel out
  always_comb begin
    retire = wb_we_i && wb_addr_i != '0;
    issue_ready_o = cnt_q[issue_dst_i] != CNT_MAX || (retire && wb_addr_i == issue_dst_i);
    accept = issue_valid_i && issue_we_i && issue_ready_o && issue_dst_i != '0;
    sb_err_d = sb_err_q || (retire && cnt_q[wb_addr_i] == '0 && !(accept && issue_dst_i == wb_addr_i));
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i)
        cnt_d[i] = '0;
      else if (accept && issue_dst_i == ADDR_W'(i) && !(retire && wb_addr_i == ADDR_W'(i)))
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (retire && wb_addr_i == ADDR_W'(i) && !(accept && issue_dst_i == ADDR_W'(i)) && cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end
  // Hazard when the source still has unretired writers (optionally net of this cycle's retire)
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    hazard_a_o = cnt_q[rd_addr_a_i] > sb_cnt_t'(retire && wb_addr_i == rd_addr_a_i);
    hazard_b_o = cnt_q[rd_addr_b_i] > sb_cnt_t'(retire && wb_addr_i == rd_addr_b_i);
`else
    hazard_a_o = cnt_q[rd_addr_a_i] != '0;
    hazard_b_o = cnt_q[rd_addr_b_i] != '0;
`endif
    sb_err_o = sb_err_q;
  end
  // Counter and sticky error state; reset clears everything
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 8x8 architectural register file with write-back scoreboard; define REGFILE_BYPASS_EN for same-cycle write-back-to-read bypass
module wb_regfile
  import wb_pkg::*;
(
  input logic         sysclk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);
  reg_data_t regs_q [NREGS];
  logic      commit;
  // A write-back commits only to r1..r7 so r0 stays zero
  always_comb commit = bus.wb_we && bus.wb_addr != '0;
  // Register array; reset clears all contents and blocks that edge's write
  always_ff @(posedge sysclk) begin
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (commit)
      regs_q[bus.wb_addr] <= bus.wb_data;
  end
  // Combinational read ports, r0 forced to zero
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    bus.rd_data_a = bus.rd_addr_a == '0 ? '0 : (commit && bus.wb_addr == bus.rd_addr_a) ? bus.wb_data : regs_q[bus.rd_addr_a];
    bus.rd_data_b = bus.rd_addr_b == '0 ? '0 : (commit && bus.wb_addr == bus.rd_addr_b) ? bus.wb_data : regs_q[bus.rd_addr_b];
`else
    bus.rd_data_a = bus.rd_addr_a == '0 ? '0 : regs_q[bus.rd_addr_a];
    bus.rd_data_b = bus.rd_addr_b == '0 ? '0 : regs_q[bus.rd_addr_b];
`endif
  end
  wb_scoreboard u_sb (
    .sysclk        (sysclk),
    .rst_n         (rst_n),
    .wb_we_i       (bus.wb_we),
    .wb_addr_i     (bus.wb_addr),
    .issue_valid_i (bus.issue_valid),
    .issue_we_i    (bus.issue_we),
    .issue_dst_i   (bus.issue_dst),
    .flush_i       (bus.flush),
    .rd_addr_a_i   (bus.rd_addr_a),
    .rd_addr_b_i   (bus.rd_addr_b),
    .issue_ready_o (bus.issue_ready),
    .hazard_a_o    (bus.hazard_a),
    .hazard_b_o    (bus.hazard_b),
    .sb_err_o      (bus.sb_err)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural register/in-flight model
module tb_wb_regfile;
  import wb_pkg::*;
  localparam int MAXC = 3;
  logic sysclk = 1'b0;
  logic rst_n = 1'b0;
  wb_regfile_if bus();
  wb_regfile dut (.sysclk(sysclk), .rst_n(rst_n), .bus(bus));
  always #5 sysclk = ~sysclk;
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int m_regs [8];
  int m_cnt [8];
  bit m_err;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_rd(int a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_we && int'(bus.wb_addr) == a) return int'(bus.wb_data);
`endif
    return m_regs[a];
  endfunction
  function automatic bit exp_haz(int a);
    int pending = m_cnt[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_we && int'(bus.wb_addr) == a && a != 0 && pending > 0) pending--;
`endif
    return pending != 0;
  endfunction
  function automatic bit exp_ready();
    int d = int'(bus.issue_dst);
    return m_cnt[d] < MAXC || (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == bus.issue_dst);
  endfunction
  // Behavioural model: registers plus count of unretired writers per register
  always @(posedge sysclk) begin
    int wa, dst;
    bit ret, acc;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
      m_err = 1'b0;
    end else begin
      wa = int'(bus.wb_addr);
      dst = int'(bus.issue_dst);
      ret = bus.wb_we && wa != 0;
      acc = bus.issue_valid && bus.issue_we && exp_ready() && dst != 0;
      if (ret && m_cnt[wa] == 0 && !(acc && dst == wa)) m_err = 1'b1;
      if (ret) m_regs[wa] = int'(bus.wb_data);
      if (bus.flush) begin
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      end else begin
        if (acc) m_cnt[dst]++;
        if (ret && m_cnt[wa] > 0) m_cnt[wa]--;
      end
    end
  end
  // Every-cycle comparison of all outputs against the model
  always @(negedge sysclk) begin
    if (chk_en) begin
      chk("rd_data_a", bus.rd_data_a, exp_rd(int'(bus.rd_addr_a)));
      chk("rd_data_b", bus.rd_data_b, exp_rd(int'(bus.rd_addr_b)));
      chk("hazard_a", bus.hazard_a, exp_haz(int'(bus.rd_addr_a)));
      chk("hazard_b", bus.hazard_b, exp_haz(int'(bus.rd_addr_b)));
      chk("issue_ready", bus.issue_ready, exp_ready());
      chk("sb_err", bus.sb_err, m_err);
    end
  end
  task automatic idle();
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.issue_valid = 1'b0; bus.issue_we = 1'b0; bus.issue_dst = '0; bus.flush = 1'b0;
  endtask
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask
  task automatic issue(int d);
    bus.issue_valid = 1'b1; bus.issue_we = 1'b1; bus.issue_dst = 3'(d);
  endtask
  task automatic wb(int a, int d);
    bus.wb_we = 1'b1; bus.wb_addr = 3'(a); bus.wb_data = 8'(d);
  endtask
  initial begin
    idle();
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_a = 3'(i); bus.rd_addr_b = 3'(7 - i); bus.issue_dst = 3'(i);
      #1;
      chk("rst_rd_a", bus.rd_data_a, 0);
      chk("rst_haz_b", bus.hazard_b, 0);
      chk("rst_ready", bus.issue_ready, 1);
      chk("rst_err", bus.sb_err, 0);
    end
    idle(); issue(3); tick();
    idle(); wb(3, 8'h5A); tick();
    idle(); bus.rd_addr_a = 3'd3; #1;
    chk("w_r3", bus.rd_data_a, 8'h5A);
    wb(0, 8'hFF); tick();
    idle(); bus.rd_addr_b = 3'd0; #1;
    chk("r0_zero", bus.rd_data_b, 0);
    issue(5); tick(); tick(); tick();
    idle(); bus.issue_dst = 3'd5; bus.rd_addr_b = 3'd5; #1;
    chk("r5_sat_ready", bus.issue_ready, 0);
    chk("r5_haz", bus.hazard_b, 1);
    issue(5); wb(5, 8'h55); #1;
    chk("r5_ready_retire", bus.issue_ready, 1);
    tick();
    idle(); bus.issue_dst = 3'd5; #1;
    chk("r5_still_sat", bus.issue_ready, 0);
    wb(5, 8'h66); tick(); tick();
    idle(); bus.rd_addr_b = 3'd5; #1;
    chk("r5_haz_cnt1", bus.hazard_b, 1);
    wb(5, 8'h67); tick();
    idle(); bus.rd_addr_b = 3'd5; #1;
    chk("r5_haz_clr", bus.hazard_b, 0);
    chk("r5_data", bus.rd_data_b, 8'h67);
    chk("r5_err", bus.sb_err, 0);
    issue(2); tick();
    idle(); wb(2, 8'h33); bus.rd_addr_a = 3'd2; #1;
`ifdef REGFILE_BYPASS_EN
    chk("r2_bypass_data", bus.rd_data_a, 8'h33);
    chk("r2_bypass_haz", bus.hazard_a, 0);
`else
    chk("r2_old_data", bus.rd_data_a, 0);
    chk("r2_old_haz", bus.hazard_a, 1);
`endif
    tick();
    idle(); bus.rd_addr_a = 3'd2; #1;
    chk("r2_data", bus.rd_data_a, 8'h33);
    chk("r2_haz", bus.hazard_a, 0);
    issue(4); tick();
    issue(6); tick();
    idle(); bus.flush = 1'b1; issue(1); wb(4, 8'h11); tick();
    idle(); bus.rd_addr_a = 3'd4; bus.rd_addr_b = 3'd6; #1;
    chk("fl_haz4", bus.hazard_a, 0);
    chk("fl_haz6", bus.hazard_b, 0);
    chk("fl_r4", bus.rd_data_a, 8'h11);
    bus.rd_addr_a = 3'd1; #1;
    chk("fl_haz1", bus.hazard_a, 0);
    chk("fl_err", bus.sb_err, 0);
    idle(); wb(7, 8'h77); tick();
    idle(); bus.rd_addr_a = 3'd7; #1;
    chk("r7_data", bus.rd_data_a, 8'h77);
    chk("r7_err", bus.sb_err, 1);
    tick(); tick();
    chk("r7_err_held", bus.sb_err, 1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; #1;
    chk("r7_err_rst", bus.sb_err, 0);
    chk("r7_rst_data", bus.rd_data_a, 0);
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(0, 299) != 0;
      bus.wb_we = 1'($urandom);
      bus.wb_addr = 3'($urandom);
      bus.wb_data = 8'($urandom);
      bus.rd_addr_a = 3'($urandom);
      bus.rd_addr_b = (n % 4 == 0) ? bus.wb_addr : 3'($urandom);
      bus.issue_valid = $urandom_range(0, 3) != 0;
      bus.issue_we = $urandom_range(0, 3) != 0;
      bus.issue_dst = (n % 3 == 0) ? 3'($urandom_range(1, 2)) : 3'($urandom);
      bus.flush = $urandom_range(0, 39) == 0;
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
